// File: rtl/reg_read_bank.sv
// ---------------------------------------------------------------------------
// reg_read_bank
//
// General register bank (NREGS x DW), reader side. Takes register writes
// from the CPU datapath, serves two independent registered read ports to
// the ALU operand stage, and contains a dump sequencer. The sequencer
// streams every register, index 0 upward, over a valid/ready debug port.
//
// Optional feature macro: REG_READ_BANK_WRITE_BYPASS_EN
//   defined   : a read or dump load of the address being written in the
//               same cycle returns the new write data.
//   undefined : such a read returns the old register contents, and no
//               forwarding logic is built.
//
// Ports:
//   CLK         clock; all state updates on the rising edge
//   resetn      asynchronous active-low reset
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     write data
//   rd_a_en     read port A enable
//   rd_a_addr   read port A address
//   rd_a_data   read port A data, registered, holds while rd_a_en=0
//   rd_b_en     read port B enable
//   rd_b_addr   read port B address
//   rd_b_data   read port B data, registered, holds while rd_b_en=0
//   dump_start  pulse to begin a dump; ignored while busy
//   dump_busy   high from the accepted start until the last beat is accepted
//   dump_valid  dump beat valid
//   dump_ready  consumer ready
//   dump_idx    register index of the current beat
//   dump_data   register contents of the current beat
//   dump_last   high with the final beat (index NREGS-1)
// ---------------------------------------------------------------------------
module reg_read_bank #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_a_en,
    input  logic [AW-1:0] rd_a_addr,
    output logic [DW-1:0] rd_a_data,
    input  logic          rd_b_en,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] rd_b_data,
    input  logic          dump_start,
    output logic          dump_busy,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Combined view of every register, one element per register.
    logic [DW-1:0] reg_file [NREGS];

    // Each register is its own flop group with a decoded write enable.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DW-1:0] q_reg;

            always_ff @(posedge CLK or negedge resetn) begin
                if (!resetn) begin
                    q_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    q_reg <= wr_data;
                end
            end

            assign reg_file[gi] = q_reg;
        end
    endgenerate

    // Dump sequencer state
    state_t        state_reg;
    logic [AW-1:0] idx_reg;
    logic          busy_reg;
    logic          valid_reg;
    logic          last_reg;
    logic [AW-1:0] dump_idx_reg;
    logic [DW-1:0] dump_data_reg;

    // Read port registers
    logic [DW-1:0] rd_a_data_reg;
    logic [DW-1:0] rd_b_data_reg;

    // Values each consumer captures on the next edge
    logic [DW-1:0] rd_a_next;
    logic [DW-1:0] rd_b_next;
    logic [DW-1:0] dump_data_next;

`ifdef REG_READ_BANK_WRITE_BYPASS_EN
    // A write to the address being read in the same cycle is forwarded, so
    // the reader sees the value the register holds after this edge.
    assign rd_a_next      = (wr_en && (wr_addr == rd_a_addr)) ? wr_data : reg_file[rd_a_addr];
    assign rd_b_next      = (wr_en && (wr_addr == rd_b_addr)) ? wr_data : reg_file[rd_b_addr];
    assign dump_data_next = (wr_en && (wr_addr == idx_reg))   ? wr_data : reg_file[idx_reg];
`else
    // No forwarding: a same-cycle write is visible only from the next cycle on.
    assign rd_a_next      = reg_file[rd_a_addr];
    assign rd_b_next      = reg_file[rd_b_addr];
    assign dump_data_next = reg_file[idx_reg];
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rd_a_data_reg <= '0;
            rd_b_data_reg <= '0;
        end else begin
            if (rd_a_en) begin
                rd_a_data_reg <= rd_a_next;
            end
            if (rd_b_en) begin
                rd_b_data_reg <= rd_b_next;
            end
        end
    end

    // Dump FSM. LOAD samples one register into the beat registers, and SEND
    // holds the beat until it is accepted. This costs one bubble cycle per
    // beat. The index stops at NREGS-1 and returns to 0 after the last
    // beat, so it never wraps.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            dump_idx_reg  <= '0;
            dump_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dump_start) begin
                        state_reg <= LOAD;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    dump_data_reg <= dump_data_next;
                    dump_idx_reg  <= idx_reg;
                    valid_reg     <= 1'b1;
                    last_reg      <= (idx_reg == AW'(NREGS - 1));
                    state_reg     <= SEND;
                end
                SEND: begin
                    // The beat registers stay untouched here, so the beat is
                    // stable while the consumer stalls.
                    if (valid_reg && dump_ready) begin
                        valid_reg <= 1'b0;
                        if (last_reg) begin
                            busy_reg  <= 1'b0;
                            idx_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rd_a_data  = rd_a_data_reg;
    assign rd_b_data  = rd_b_data_reg;
    assign dump_busy  = busy_reg;
    assign dump_valid = valid_reg;
    assign dump_idx   = dump_idx_reg;
    assign dump_data  = dump_data_reg;
    assign dump_last  = last_reg;

endmodule

// File: tb/tb_reg_read_bank.sv
// ---------------------------------------------------------------------------
// tb_reg_read_bank
//
// Directed test of reg_read_bank using a scoreboard. The stimulus pushes
// expected read results and dump beats into queues. A monitor on the
// falling edge pops read results one cycle after each checked read. It
// also compares every presented dump beat against the head of the dump
// queue, and pops that entry when the beat is accepted.
// ---------------------------------------------------------------------------
module tb_reg_read_bank;

    localparam int NREGS = 8;
    localparam int DW    = 16;
    localparam int AW    = 3;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_a_en = 1'b0;
    logic [AW-1:0] rd_a_addr = '0;
    logic [DW-1:0] rd_a_data;
    logic          rd_b_en = 1'b0;
    logic [AW-1:0] rd_b_addr = '0;
    logic [DW-1:0] rd_b_data;
    logic          dump_start = 1'b0;
    logic          dump_busy;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          dump_last;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    beat_t         dq[$];

    logic chk_a = 1'b0, chk_b = 1'b0;
    logic chk_a_d = 1'b0, chk_b_d = 1'b0;

    reg_read_bank #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_a_en    (rd_a_en),
        .rd_a_addr  (rd_a_addr),
        .rd_a_data  (rd_a_data),
        .rd_b_en    (rd_b_en),
        .rd_b_addr  (rd_b_addr),
        .rd_b_data  (rd_b_data),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_a(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_a_en = 1'b1; rd_a_addr = a; chk_a = 1'b1; qa.push_back(exp);
        tick();
        rd_a_en = 1'b0; chk_a = 1'b0;
    endtask

    task automatic push_dump(input logic [DW-1:0] base);
        for (int i = 0; i < NREGS; i++) begin
            beat_t b;
            b.idx  = AW'(i);
            b.data = base + DW'(i);
            b.last = (i == NREGS - 1);
            dq.push_back(b);
        end
    endtask

    task automatic wait_idx(input int want, input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (dump_valid && (dump_idx == AW'(want))) break;
        end
        if (n == 200) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (!dump_busy) break;
        end
        if (n == 200) timeout(name);
    endtask

    // Checked-read flags are delayed one edge, so the monitor compares on
    // the falling edge after the edge that captured the read.
    always @(posedge CLK) begin
        chk_a_d <= chk_a;
        chk_b_d <= chk_b;
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (chk_a_d) begin
            if (qa.size() == 0) timeout("rd_a_queue_empty");
            else check("rd_a_data", rd_a_data, qa.pop_front());
        end
        if (chk_b_d) begin
            if (qb.size() == 0) timeout("rd_b_queue_empty");
            else check("rd_b_data", rd_b_data, qb.pop_front());
        end
        if (resetn && dump_valid) begin
            if (dq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dump_unexpected_beat: got idx %0d data 0x%0h, expected no beat",
                         dump_idx, dump_data);
            end else begin
                check("dump_idx",  32'(dump_idx),  32'(dq[0].idx));
                check("dump_data", 32'(dump_data), 32'(dq[0].data));
                check("dump_last", 32'(dump_last), 32'(dq[0].last));
                if (dump_ready) void'(dq.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] coll_exp;

        // ---- Reset state ----
        repeat (2) @(posedge CLK);
        #1 resetn = 1'b1;
        check("reset_rd_a", 32'(rd_a_data), 0);
        check("reset_rd_b", 32'(rd_b_data), 0);
        check("reset_busy", 32'(dump_busy), 0);
        check("reset_valid", 32'(dump_valid), 0);
        check("reset_idx", 32'(dump_idx), 0);

        // ---- Asynchronous reset mid-cycle ----
        write_reg(3'd5, 16'h1234);
        read_a(3'd5, 16'h1234);
        @(negedge CLK);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_rd_a", 32'(rd_a_data), 0);
        @(posedge CLK);
        #1 resetn = 1'b1;
        read_a(3'd5, 16'h0000);

        // ---- Write / read latency and hold ----
        write_reg(3'd3, 16'hBEEF);
        read_a(3'd3, 16'hBEEF);
        chk_a = 1'b1; qa.push_back(16'hBEEF);
        tick();
        chk_a = 1'b0;

        // ---- Both ports read the same address ----
        rd_a_en = 1'b1; rd_a_addr = 3'd3; chk_a = 1'b1; qa.push_back(16'hBEEF);
        rd_b_en = 1'b1; rd_b_addr = 3'd3; chk_b = 1'b1; qb.push_back(16'hBEEF);
        tick();
        rd_a_en = 1'b0; rd_b_en = 1'b0; chk_a = 1'b0; chk_b = 1'b0;

        // ---- Same-cycle write/read collision ----
        write_reg(3'd2, 16'h1111);
`ifdef REG_READ_BANK_WRITE_BYPASS_EN
        coll_exp = 16'h2222;
`else
        coll_exp = 16'h1111;
`endif
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        rd_b_en = 1'b1; rd_b_addr = 3'd2; chk_b = 1'b1; qb.push_back(coll_exp);
        rd_a_en = 1'b1; rd_a_addr = 3'd3; chk_a = 1'b1; qa.push_back(16'hBEEF);
        tick();
        wr_en = 1'b0; rd_a_en = 1'b0; chk_a = 1'b0;
        qb.push_back(16'h2222);
        tick();
        rd_b_en = 1'b0; chk_b = 1'b0;

        // ---- Full dump ----
        for (int i = 0; i < NREGS; i++) write_reg(AW'(i), 16'hA000 + DW'(i));
        push_dump(16'hA000);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_idx(NREGS - 1, "wait_last_beat");
        check("busy_during_last", 32'(dump_busy), 1);
        @(negedge CLK);
        check("busy_after_last", 32'(dump_busy), 0);
        check("valid_after_last", 32'(dump_valid), 0);
        check("dump1_beats_left", dq.size(), 0);

        // ---- Backpressure on beat 4, with an ignored start ----
        push_dump(16'hA000);
        @(posedge CLK); #1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_idx(3, "wait_beat3");
        @(posedge CLK); #1;
        dump_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            dump_start = (k == 2);
            tick();
        end
        dump_start = 1'b0;
        check("stall_idx", 32'(dump_idx), 4);
        dump_ready = 1'b1;
        wait_idle("wait_idle_bp");
        repeat (4) tick();
        check("bp_no_restart_busy", 32'(dump_busy), 0);
        check("dump2_beats_left", dq.size(), 0);

        // ---- Reset during beat 3 ----
        push_dump(16'hA000);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_idx(3, "wait_beat3_rst");
        #2 resetn = 1'b0;
        #1;
        check("midrst_valid", 32'(dump_valid), 0);
        check("midrst_busy", 32'(dump_busy), 0);
        check("midrst_idx", 32'(dump_idx), 0);
        dq.delete();
        @(posedge CLK);
        #1 resetn = 1'b1;
        for (int i = 0; i < NREGS; i++) write_reg(AW'(i), 16'hC000 + DW'(i));
        push_dump(16'hC000);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_idle("wait_idle_restart");
        repeat (3) tick();
        check("dump3_beats_left", dq.size(), 0);
        check("rd_queues_left", qa.size() + qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
